// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing constants, FU bit-index offsets and helpers for the CDB completion arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned N              = 3;
  localparam int unsigned NUM_FU_ALU     = 3;
  localparam int unsigned NUM_FU_BRANCH  = 1;
  localparam int unsigned NUM_FU_MULT    = 2;
  localparam int unsigned LOAD_BUFFER_SZ = 4;
  localparam int unsigned STARVE_LIMIT   = 4;

  localparam int unsigned NUM_FU_TOTAL = LOAD_BUFFER_SZ + NUM_FU_MULT + NUM_FU_ALU + NUM_FU_BRANCH;
  localparam int unsigned VAR_REQ      = LOAD_BUFFER_SZ + NUM_FU_MULT;

  // Bit positions of each FU class within one grant slot (load at LSB, branch at MSB)
  localparam int unsigned FU_IDX_LOAD   = 0;
  localparam int unsigned FU_IDX_MULT   = FU_IDX_LOAD + LOAD_BUFFER_SZ;
  localparam int unsigned FU_IDX_ALU    = FU_IDX_MULT + NUM_FU_MULT;
  localparam int unsigned FU_IDX_BRANCH = FU_IDX_ALU + NUM_FU_ALU;

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned PTR_W = $clog2(VAR_REQ);
  localparam int unsigned LIM_W = $clog2(N + 1);

  typedef logic [AGE_W-1:0] age_t;

  // (base + off) mod VAR_REQ, valid for base < VAR_REQ and off < VAR_REQ
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int unsigned off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(VAR_REQ)) s = s - (PTR_W+1)'(VAR_REQ);
    return s[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin selector: grants up to `budget` requesters scanning upward from start_ptr with wrap.
module rr_picker
  import cdb_arbiter_pkg::*;
(
  input  logic [VAR_REQ-1:0] req,
  input  logic [PTR_W-1:0]   start_ptr,
  input  logic [LIM_W-1:0]   budget,
  output logic [VAR_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   next_ptr,
  output logic               any_gnt
);

  logic [LIM_W-1:0] cnt;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt      = '0;
    next_ptr = start_ptr;
    any_gnt  = 1'b0;
    cnt      = '0;
    idx      = '0;
    for (int unsigned i = 0; i < VAR_REQ; i++) begin
      idx = wrap_idx(start_ptr, i);
      if (req[idx] && (cnt < budget)) begin
        gnt[idx] = 1'b1;
        cnt      = cnt + LIM_W'(1);
        next_ptr = wrap_idx(idx, 1);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB completion arbiter: fixed-latency units first, then starving variable units, then round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_FU_ALU-1:0]                 alu_done,
  input  logic [NUM_FU_BRANCH-1:0]              branch_done,
  input  logic [NUM_FU_MULT-1:0]                mult_cdb_valid,
  input  logic [LOAD_BUFFER_SZ-1:0]             load_cdb_valid,
  output logic [N-1:0][NUM_FU_TOTAL-1:0]        complete_gnt_bus,
  output logic [NUM_FU_MULT-1:0]                mult_cdb_gnt,
  output logic [LOAD_BUFFER_SZ-1:0]             load_cdb_gnt,
  output logic [LIM_W-1:0]                      fixed_issue_limit
);

  localparam int unsigned FIX_W = $clog2(NUM_FU_ALU + NUM_FU_BRANCH + 1);

  logic [VAR_REQ-1:0]             var_valid;
  logic [VAR_REQ-1:0]             starve_gnt;
  logic [VAR_REQ-1:0]             rr_gnt;
  logic [VAR_REQ-1:0]             var_gnt;
  logic [N-1:0][NUM_FU_TOTAL-1:0] bus_pri;
  logic [N-1:0][NUM_FU_TOTAL-1:0] bus_all;
  logic [LIM_W-1:0]               fill_pri;
  logic [LIM_W-1:0]               fill_rr;
  logic [LIM_W-1:0]               rr_budget;
  logic [FIX_W-1:0]               fixed_cnt;
  logic [PTR_W-1:0]               rr_next;
  logic [PTR_W-1:0]               rr_idx;
  logic                           rr_any;
  logic [PTR_W:0]                 starve_cnt;

  age_t             age_q [VAR_REQ];
  age_t             age_d [VAR_REQ];
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LIM_W-1:0] reserve_q, reserve_d;

  assign var_valid = {mult_cdb_valid, load_cdb_valid};

  always_comb begin
    bus_pri    = '0;
    fill_pri   = '0;
    fixed_cnt  = '0;
    starve_gnt = '0;
    for (int unsigned b = 0; b < NUM_FU_BRANCH; b++) begin
      if (branch_done[b]) begin
        fixed_cnt = fixed_cnt + FIX_W'(1);
        if (fill_pri < LIM_W'(N)) begin
          bus_pri[fill_pri][FU_IDX_BRANCH+b] = 1'b1;
          fill_pri = fill_pri + LIM_W'(1);
        end
      end
    end
    for (int unsigned a = 0; a < NUM_FU_ALU; a++) begin
      if (alu_done[a]) begin
        fixed_cnt = fixed_cnt + FIX_W'(1);
        if (fill_pri < LIM_W'(N)) begin
          bus_pri[fill_pri][FU_IDX_ALU+a] = 1'b1;
          fill_pri = fill_pri + LIM_W'(1);
        end
      end
    end
    // Variable requester index k coincides with its FU bit position (load, then mult)
    for (int unsigned k = 0; k < VAR_REQ; k++) begin
      if (var_valid[k] && (age_q[k] >= AGE_W'(STARVE_LIMIT)) && (fill_pri < LIM_W'(N))) begin
        bus_pri[fill_pri][FU_IDX_LOAD+k] = 1'b1;
        starve_gnt[k] = 1'b1;
        fill_pri = fill_pri + LIM_W'(1);
      end
    end
    rr_budget = LIM_W'(N) - fill_pri;
  end

  rr_picker u_rr_picker (
    .req       (var_valid & ~starve_gnt),
    .start_ptr (rr_ptr_q),
    .budget    (rr_budget),
    .gnt       (rr_gnt),
    .next_ptr  (rr_next),
    .any_gnt   (rr_any)
  );

  // Round-robin winners occupy the remaining slots in scan order from rr_ptr
  always_comb begin
    bus_all = bus_pri;
    fill_rr = fill_pri;
    rr_idx  = '0;
    for (int unsigned i = 0; i < VAR_REQ; i++) begin
      rr_idx = wrap_idx(rr_ptr_q, i);
      if (rr_gnt[rr_idx] && (fill_rr < LIM_W'(N))) begin
        bus_all[fill_rr][FU_IDX_LOAD+rr_idx] = 1'b1;
        fill_rr = fill_rr + LIM_W'(1);
      end
    end
  end

  always_comb begin
    complete_gnt_bus = reset ? bus_all : '0;
    var_gnt = '0;
    for (int unsigned s = 0; s < N; s++) begin
      var_gnt = var_gnt | complete_gnt_bus[s][FU_IDX_LOAD +: VAR_REQ];
    end
    load_cdb_gnt      = var_gnt[LOAD_BUFFER_SZ-1:0];
    mult_cdb_gnt      = var_gnt[VAR_REQ-1:LOAD_BUFFER_SZ];
    fixed_issue_limit = LIM_W'(N) - reserve_q;
  end

  always_comb begin
    starve_cnt = '0;
    for (int unsigned k = 0; k < VAR_REQ; k++) begin
      if (var_valid[k] && !var_gnt[k]) begin
        age_d[k] = (age_q[k] == AGE_W'(STARVE_LIMIT)) ? age_q[k] : age_q[k] + AGE_W'(1);
      end else begin
        age_d[k] = '0;
      end
      if (age_d[k] >= AGE_W'(STARVE_LIMIT)) starve_cnt = starve_cnt + (PTR_W+1)'(1);
    end
    reserve_d = (starve_cnt > (PTR_W+1)'(N)) ? LIM_W'(N) : starve_cnt[LIM_W-1:0];
    rr_ptr_d  = rr_any ? rr_next : rr_ptr_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      reserve_q <= '0;
      for (int unsigned k = 0; k < VAR_REQ; k++) age_q[k] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      reserve_q <= reserve_d;
      for (int unsigned k = 0; k < VAR_REQ; k++) age_q[k] <= age_d[k];
      assert (fixed_cnt <= FIX_W'(N))
        else $warning("cdb_arbiter: fixed completions %0d exceed CDB width, extra dropped", fixed_cnt);
    end
  end

endmodule
